alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/result interface. Accepts one decoded register-register ALU operation, drives the Y operand, the B operand and the 5-bit opcode into the ALU, and captures the 64-bit ALU result into its internal Z register.
- Sequences the result write-back: Z[31:0] goes to Rz for single-word ops; for MUL/DIV it goes to LO, then Z[63:32] goes to HI.
- Sits between the control unit and the ALU, replacing the hand-driven Yin/Zin/ZLo/ZHi strobes.

Parameters:
- EXEC_WAIT, 1, extra clock cycles held in EXEC for MUL/DIV before capture (minimum 0). Non-MUL/DIV ops always use 0.
- OPW, 5, opcode width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  OPW  ALU opcode for this request.
- ra_val  in  32  first operand, loaded into Y.
- rb_val  in  32  second operand, driven as B.
- alu_result  in  64  ALU output, valid one posedge after operands and control are applied (the ALU updates on negedge).
- y_out  out  32  Y operand to ALU.
- b_out  out  32  B operand to ALU.
- alu_control  out  OPW  opcode to ALU.
- inc_pc  out  1  tied 0; this block never requests PC increment.
- busy  out  1  high from accept until DONE inclusive.
- wb_data  out  32  write-back data.
- wr_rz, wr_lo, wr_hi  out  1 each  one-hot write strobes, valid with wb_data for one cycle.
- done  out  1  one-cycle pulse at end of operation.
- bad_op  out  1  with done; opcode not in the supported set.

Behaviour:
- Reset (clear=1 at posedge, in any state, including mid-operation):
  - state goes to IDLE.
  - y_out, b_out, alu_control, Z, wb_data all go to 0.
  - All strobes, busy, done and bad_op go to 0.
  - Any in-flight operation is discarded with no write strobe.
- Supported opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- IDLE:
  - On start=1 with a supported opcode: latch opcode, y_out<=ra_val, b_out<=rb_val, busy<=1, go to EXEC.
  - On start=1 with an unsupported opcode: go to DONE with bad_op=1. No ALU drive, no write strobes.
  - start while busy is ignored; it is neither queued nor errored.
- EXEC: alu_control driven with the latched opcode. It is held for 1 cycle, or 1+EXEC_WAIT cycles for MUL/DIV, using a wait counter that counts down to 0.
- CAPTURE: Z<=alu_result. alu_control returns to 0 the following cycle.
- WB_LO:
  - MUL/DIV: wb_data=Z[31:0], wr_lo=1. Next state is WB_HI.
  - Otherwise: wb_data=Z[31:0], wr_rz=1. Next state is DONE.
- WB_HI: wb_data=Z[63:32], wr_hi=1. Next state is DONE.
- DONE: done=1 for one cycle; busy drops the cycle after, then IDLE. A start arriving in the DONE cycle is ignored.
- Latency from start to done:
  - Single-word op: 4 cycles.
  - MUL/DIV: 5+EXEC_WAIT cycles.
  - Bad op: 1 cycle.
- At most one of wr_rz/wr_lo/wr_hi is high in any cycle.
- wb_data holds its last value between strobes.
- Y and B are held stable from accept through CAPTURE, regardless of ra_val/rb_val changes.
- The Z upper half is ignored for non-MUL/DIV ops, even if nonzero.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (shared with the ALU, so both ends use one definition).
  - state encoding enum: IDLE, EXEC, CAPTURE, WB_LO, WB_HI, DONE.
  - an is_wide(opcode) function (true for MUL and DIV).
  - an is_supported(opcode) function.
- No sub-module; the wait counter is inline. A plain-register 64-bit Z is inlined too.

Test Plan:
- ADD, ra=0x0000_0005, rb=0x0000_0003 (ALU model returns 8) -> y_out=5, b_out=3, alu_control=00011 in EXEC; wr_rz with wb_data=0x8 at cycle 3; done at cycle 4; wr_lo and wr_hi never asserted.
- MUL, EXEC_WAIT=1, ALU returns 0x0000_0001_FFFF_FFFE -> wr_lo with 0xFFFF_FFFE, then wr_hi with 0x0000_0001 on the next cycle; done at cycle 6.
- Opcode 11111 -> done=1 and bad_op=1 one cycle after start; no strobes; alu_control stays 0.
- start pulsed again during EXEC, and during DONE, with different operands -> ignored; the first op's result is written once; y_out is unchanged until the next IDLE accept.
- clear asserted in WB_LO of a DIV -> next cycle all outputs are 0, state is IDLE, no wr_hi ever issued; a following SUB 10-4 completes with wb_data=6.
- ra_val/rb_val toggled every cycle after accept -> y_out and b_out hold the accepted values through CAPTURE.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode map, sequencer state encoding and opcode classifiers
// Rev 1.0 : initial release
// ============================================================================
package alu_pkg;

  localparam int OPW_DEF = 5;
  typedef logic [OPW_DEF-1:0] opcode_t;

  // Opcode map shared with the ALU so both ends use one definition.
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    CAPTURE = 3'd2,
    WB_LO   = 3'd3,
    WB_HI   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Wide ops produce a 64-bit result written back as LO then HI.
  function automatic logic is_wide(opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_supported(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer_if : request, ALU operand/result and write-back bundle
// Rev 1.0 : initial release
// ============================================================================
interface alu_op_sequencer_if #(
  parameter int OPW = 5
);

  logic            start;
  logic [OPW-1:0]  opcode;
  logic [31:0]     ra_val;
  logic [31:0]     rb_val;
  logic [63:0]     alu_result;
  logic [31:0]     y_out;
  logic [31:0]     b_out;
  logic [OPW-1:0]  alu_control;
  logic            inc_pc;
  logic            busy;
  logic [31:0]     wb_data;
  logic            wr_rz;
  logic            wr_lo;
  logic            wr_hi;
  logic            done;
  logic            bad_op;

  // master: the sequencer itself
  modport master (
    input  start, opcode, ra_val, rb_val, alu_result,
    output y_out, b_out, alu_control, inc_pc, busy, wb_data,
           wr_rz, wr_lo, wr_hi, done, bad_op
  );

  // slave: control unit / ALU side
  modport slave (
    output start, opcode, ra_val, rb_val, alu_result,
    input  y_out, b_out, alu_control, inc_pc, busy, wb_data,
           wr_rz, wr_lo, wr_hi, done, bad_op
  );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer : drives one ALU op, captures Z, sequences Rz/LO/HI write-back
// Rev 1.0 : initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int EXEC_WAIT = 1,
  parameter int OPW       = 5
) (
  input  logic clock,
  input  logic clear,
  alu_op_sequencer_if.master bus
);

  localparam int CW = (EXEC_WAIT > 0) ? $clog2(EXEC_WAIT + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [OPW-1:0]  r_op;
  logic [OPW-1:0]  r_alu_ctrl;
  logic [31:0]     r_y;
  logic [31:0]     r_b;
  logic [63:0]     r_z;
  logic [31:0]     r_wb_hold;
  logic [CW-1:0]   r_wait;
  logic            r_bad;

  logic [31:0]     w_wb_data;
  logic            w_wr_rz;
  logic            w_wr_lo;
  logic            w_wr_hi;
  logic            w_done;

  always_ff @(posedge clock) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_wb_data = r_wb_hold;
    w_wr_rz   = 1'b0;
    w_wr_lo   = 1'b0;
    w_wr_hi   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = is_supported(bus.opcode) ? EXEC : DONE;
      end
      EXEC: begin
        if (r_wait == '0) w_next = CAPTURE;
      end
      CAPTURE: w_next = WB_LO;
      WB_LO: begin
        w_wb_data = r_z[31:0];
        if (is_wide(r_op)) begin
          w_wr_lo = 1'b1;
          w_next  = WB_HI;
        end else begin
          w_wr_rz = 1'b1;
          w_next  = DONE;
        end
      end
      WB_HI: begin
        w_wb_data = r_z[63:32];
        w_wr_hi   = 1'b1;
        w_next    = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_op       <= '0;
      r_alu_ctrl <= '0;
      r_y        <= '0;
      r_b        <= '0;
      r_z        <= '0;
      r_wb_hold  <= '0;
      r_wait     <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_wb_hold <= w_wb_data;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (is_supported(bus.opcode)) begin
              r_op       <= bus.opcode;
              r_alu_ctrl <= bus.opcode;
              r_y        <= bus.ra_val;
              r_b        <= bus.rb_val;
              r_wait     <= is_wide(bus.opcode) ? CW'(EXEC_WAIT) : '0;
              r_bad      <= 1'b0;
            end else begin
              r_bad      <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_wait != '0) r_wait <= r_wait - 1'b1;
        end
        CAPTURE: begin
          // Control stays on the ALU through the capture edge, then drops.
          r_z        <= bus.alu_result;
          r_alu_ctrl <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.y_out       = r_y;
  assign bus.b_out       = r_b;
  assign bus.alu_control = r_alu_ctrl;
  assign bus.inc_pc      = 1'b0;
  assign bus.busy        = (r_state != IDLE);
  assign bus.wb_data     = w_wb_data;
  assign bus.wr_rz       = w_wr_rz;
  assign bus.wr_lo       = w_wr_lo;
  assign bus.wr_hi       = w_wr_hi;
  assign bus.done        = w_done;
  assign bus.bad_op      = w_done & r_bad;

endmodule
`default_nettype wire
